// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
//   Constants and types shared by reg_mem and the blocks that master it.
//   MEM_DATA_WIDTH / MEM_ADDR_BITS are the default word and address widths
//   of the register memory. state_e is the control state of the stream reader.
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_DATA_WIDTH = 8;
  localparam int MEM_ADDR_BITS  = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    PRESENT = 2'd2,
    FINISH  = 2'd3
  } state_e;

endpackage : mem_pkg

// File: rtl/reg_mem.sv
// -----------------------------------------------------------------------------
// reg_mem
//   Small register memory, 2**ADDR_BITS words of DATA_WIDTH bits.
//   Synchronous write. Read is combinational (READ_LATENCY=0) or registered
//   (READ_LATENCY=1, data_out valid one edge after addr).
// Ports:
//   clk       system clock
//   wen       write enable, writes data_in to addr on the rising edge
//   addr      read/write address
//   data_in   write data
//   data_out  read data
// -----------------------------------------------------------------------------
module reg_mem
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH   = MEM_DATA_WIDTH,
  parameter int ADDR_BITS    = MEM_ADDR_BITS,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  wen,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_BITS];

  // NOTE: the storage array has no reset; clearing every word would turn it
  // into plain flops with a reset tree and its contents are always written
  // before they are read.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem_q[addr] <= data_in;
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      assign data_out = mem_q[addr];
    end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic [DATA_WIDTH-1:0] rd_data_d;

      always_comb begin
        rd_data_d = mem_q[addr];
      end

      always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
      end

      assign data_out = rd_data_q;
    end
  endgenerate

endmodule : reg_mem

// File: rtl/mem_stream_reader.sv
// -----------------------------------------------------------------------------
// mem_stream_reader
//   Read-side master for reg_mem. On an accepted start it reads `length`
//   contiguous words beginning at `base_addr` (address wraps modulo
//   2**ADDR_BITS) and presents them one at a time on a valid/ready stream.
//   Non-pipelined: one word in flight, one word per READ_LATENCY+2 cycles.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              request a run; honoured only in IDLE
//   base_addr, length  first address and word count (0..2**ADDR_BITS)
//   busy               high from the accepted start until the run completes
//   done               one-cycle pulse at run completion
//   mem_addr, mem_wen  address / write enable to reg_mem (wen is always 0)
//   mem_data           read data from reg_mem
//   out_data/valid     stream payload and valid
//   out_ready          stream ready from the consumer
// -----------------------------------------------------------------------------
module mem_stream_reader
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH   = MEM_DATA_WIDTH,
  parameter int ADDR_BITS    = MEM_ADDR_BITS,
  parameter int READ_LATENCY = 1   // 0 = combinational memory, 1 = registered
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  base_addr,
  input  logic [ADDR_BITS:0]    length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // Value of the latency counter on the edge that captures mem_data.
  // The counter runs 0..READ_LATENCY, i.e. READ_LATENCY+1 edges in READ.
  localparam logic LAT_LAST = 1'(READ_LATENCY);

  state_e                state_q,     state_d;
  logic [ADDR_BITS-1:0]  mem_addr_q,  mem_addr_d;
  logic [ADDR_BITS:0]    remaining_q, remaining_d;
  logic                  lat_cnt_q,   lat_cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;

  // NOTE: every signal is given its hold value first so that paths which do
  // not assign it cannot infer a latch.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    remaining_d = remaining_q;
    lat_cnt_d   = lat_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = done_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            mem_addr_d  = base_addr;
            remaining_d = length;
            lat_cnt_d   = 1'b0;
            busy_d      = 1'b1;
            state_d     = READ;
          end else begin
            // Empty run: skip straight to the completion pulse.
            done_d  = 1'b1;
            state_d = FINISH;
          end
        end
      end

      READ: begin
        if (lat_cnt_q == LAT_LAST) begin
          out_data_d  = mem_data;
          out_valid_d = 1'b1;
          state_d     = PRESENT;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end

      PRESENT: begin
        // out_data_q is only reloaded in READ, so it stays stable under
        // backpressure without extra gating.
        if (out_ready) begin
          out_valid_d = 1'b0;
          lat_cnt_d   = 1'b0;
          if (remaining_q > 1) begin
            mem_addr_d  = mem_addr_q + 1'b1;   // wraps modulo 2**ADDR_BITS
            remaining_d = remaining_q - 1'b1;
            state_d     = READ;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FINISH;
          end
        end
      end

      FINISH: begin
        // start is deliberately not looked at here.
        done_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      remaining_q <= '0;
      lat_cnt_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      remaining_q <= remaining_d;
      lat_cnt_q   <= lat_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wen   = 1'b0;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule : mem_stream_reader
